// File: rtl/div_seq.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// holds the front end through `stop`, and aborts cleanly on flush.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stop,
    output logic        div_complete,
    output logic        busy,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] prem_q, prem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;

    logic [32:0] step_trial;
    logic        step_qbit;
    logic [31:0] step_prem;
    logic [31:0] step_dvd;

    // prem < divisor always holds, so a failed trial never needs bit 32.
    always_comb begin
        step_trial = {prem_q, dvd_q[31]};
        step_qbit  = (step_trial >= {1'b0, dvs_q});
        step_prem  = step_qbit ? (step_trial[31:0] - dvs_q) : step_trial[31:0];
        step_dvd   = {dvd_q[30:0], step_qbit};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_req) begin
                        dvd_d      = (div_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
                        dvs_d      = (div_signed & src_b[31]) ? (32'd0 - src_b) : src_b;
                        neg_quot_d = div_signed & (src_a[31] ^ src_b[31]);
                        neg_rem_d  = div_signed & src_a[31];
                        prem_d     = 32'd0;
                        cnt_d      = 5'd0;
                        state_d    = CALC;
                    end
                end
                CALC: begin
                    dvd_d  = step_dvd;
                    prem_d = step_prem;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        // Results are registered on the last step so they are valid in DONE.
                        quot_d  = neg_quot_q ? (32'd0 - step_dvd) : step_dvd;
                        rem_d   = neg_rem_q ? (32'd0 - step_prem) : step_prem;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            prem_q     <= 32'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    always_comb begin
        stop = ~rst & ~flush & (((state_q == IDLE) & div_req) | (state_q == CALC));
        div_complete = (state_q == DONE) & ~flush;
        busy = (state_q != IDLE);
        quot = quot_q;
        rem  = rem_q;
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed cycle-exact cases plus random divides, with a
// queue-based scoreboard checked by an independent completion monitor.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        div_req;
    logic        div_signed;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stop;
    logic        div_complete;
    logic        busy;
    logic [31:0] quot;
    logic [31:0] rem;

    logic [63:0] exp_q[$];
    int          checks;
    int          fails;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .stop         (stop),
        .div_complete (div_complete),
        .busy         (busy),
        .quot         (quot),
        .rem          (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: MIPS-style truncating division with the documented corner cases.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    always begin
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (div_complete === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_complete: got quot=0x%08h rem=0x%08h expected no pulse", quot, rem);
            end else begin
                e = exp_q.pop_front();
                chk("quot", quot, e[63:32]);
                chk("rem", rem, e[31:0]);
            end
        end
    end

    // Starts at a negedge in IDLE; cycle k is observed 1ns after the k-th negedge.
    task automatic run_checked(input logic s, input logic [31:0] a, input logic [31:0] b, input bit chain);
        logic [63:0] e;
        e = model(s, a, b);
        exp_q.push_back(e);
        for (int k = 0; k < 34; k++) begin
            if (k == 0) begin
                div_req = 1'b1;
                div_signed = s;
                src_a = a;
                src_b = b;
            end
            if (k == 1) begin
                src_a = $urandom;
                src_b = $urandom;
                div_signed = ~s;
            end
            #1;
            chk("stop", {31'd0, stop}, {31'd0, (k <= 32)});
            chk("busy", {31'd0, busy}, {31'd0, (k >= 1)});
            chk("div_complete", {31'd0, div_complete}, {31'd0, (k == 33)});
            if (k == 33 && !chain) div_req = 1'b0;
            @(negedge clk);
        end
        last_q = e[63:32];
        last_r = e[31:0];
    endtask

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        checks = 0;
        fails = 0;
        rst = 1'b1;
        div_req = 1'b1;
        div_signed = 1'b0;
        src_a = 32'd100;
        src_b = 32'd7;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stop", {31'd0, stop}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_complete", {31'd0, div_complete}, 32'd0);
        chk("reset_quot", quot, 32'd0);
        chk("reset_rem", rem, 32'd0);
        div_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_checked(1'b0, 32'd100, 32'd7, 1'b0);
        run_checked(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_checked(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_checked(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_checked(1'b0, 32'd5, 32'd0, 1'b0);

        // Flush at cycle 10 of an active divide; nothing is pushed for it.
        div_req = 1'b1;
        div_signed = 1'b0;
        src_a = 32'd100;
        src_b = 32'd7;
        for (int k = 0; k < 10; k++) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stop", {31'd0, stop}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        div_req = 1'b0;
        #1;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_complete", {31'd0, div_complete}, 32'd0);
        chk("flush_hold_quot", quot, last_q);
        chk("flush_hold_rem", rem, last_r);
        @(negedge clk);
        run_checked(1'b0, 32'd9, 32'd3, 1'b0);

        run_checked(1'b0, 32'd50, 32'd5, 1'b1);
        run_checked(1'b0, 32'd9, 32'd4, 1'b0);

        // Reset at cycle 20 of an active divide.
        div_req = 1'b1;
        div_signed = 1'b0;
        src_a = 32'd100;
        src_b = 32'd7;
        for (int k = 0; k < 20; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_stop", {31'd0, stop}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        div_req = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_stop2", {31'd0, stop}, 32'd0);
        chk("rst_mid_complete", {31'd0, div_complete}, 32'd0);
        chk("rst_mid_quot", quot, 32'd0);
        chk("rst_mid_rem", rem, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_checked(s, a, b, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit divide sequencer for the pipeline's DIV/DIVU instructions. It accepts a divide request from the EXE stage, computes one quotient bit per cycle, and holds the front end through its `stop` output while busy. It pulses `div_complete` when results are ready, which releases the decode stage's dependent-branch stall, and aborts cleanly on an exception/ERET flush.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `div_req`  in  1  EXE holds a valid DIV/DIVU; requester holds it and its operands stable until `div_complete`
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU
- `src_a`  in  32  dividend
- `src_b`  in  32  divisor
- `flush`  in  1  exception/ERET sweep; aborts any operation
- `stop`  out  1  pipeline hold request to IF/ID/EXE
- `div_complete`  out  1  one-cycle pulse, result valid
- `busy`  out  1  state != IDLE
- `quot`  out  32  quotient (LO), registered
- `rem`  out  32  remainder (HI), registered

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - `div_req & ~flush` latches the following:
    - |a| and |b| (magnitudes only when `div_signed`; otherwise raw values)
    - `neg_q = signed & (a[31]^b[31])`
    - `neg_r = signed & a[31]`
    - partial remainder = 0, counter = 0
  - Then goes to CALC.
- CALC, one restoring step per cycle:
  - `t = {prem[31:0], dvd[31]}` (33 bits).
  - If `t >= {1'b0,|b|}`: `prem = t - |b|`, qbit = 1. Otherwise `prem = t`, qbit = 0.
  - `dvd = {dvd[30:0], qbit}`.
  - counter increments. Counter == 31 → DONE.
- DONE:
  - `quot` ← `neg_q ? -dvd : dvd`.
  - `rem` ← `neg_r ? -prem : prem`.
  - `div_complete` = 1.
  - Next state is IDLE unconditionally.
- `stop = (state==IDLE & div_req & ~flush) | (state==CALC)`. `stop` is combinational and is 0 in DONE, so the pipeline advances on DONE's edge.
- A `div_req` seen in IDLE is always a new instruction. The cycle after DONE is IDLE and may start a back-to-back divide.
- Flush:
  - In any state, `flush` forces IDLE on the next edge.
  - No `div_complete`; `quot`/`rem` keep their previous values.
  - In the flush cycle `stop` = 0.
  - `flush` beats `div_req`.
- Divide by zero: no trap; the algorithm runs unchanged.
  - DIVU gives `quot`=0xFFFFFFFF, `rem`=`src_a`.
  - DIV applies sign correction to those magnitudes.
- Overflow: 0x80000000 / -1 signed gives `quot`=0x80000000, `rem`=0 (magnitude 0x80000000, negation wraps).
- Negation and magnitude are 32-bit two's complement; carries beyond bit 31 are discarded.

## Timing
- Reset (rst=1 at an edge) sets:
  - state=IDLE
  - `quot`=0, `rem`=0
  - `div_complete`=0, `busy`=0
  - internal counter/regs = 0
  - `stop`=0 while rst is high
- Latency, with `div_req` first seen in IDLE at cycle 0:
  - CALC occupies cycles 1–32.
  - DONE is cycle 33: `div_complete`=1, `quot`/`rem` valid and stable from cycle 33 until the next DONE.
  - `stop`=1 in cycles 0–32.
  - `busy`=1 in cycles 1–33.
- Throughput: one divide per 34 cycles back-to-back (IDLE accept cycle, 32 CALC, DONE).
- Operand changes on `src_a`/`src_b` after cycle 0 have no effect.
- `rst` mid-CALC returns to IDLE next edge with outputs cleared; no pulse.

## Test plan
- DIVU 100/7 at cycle 0 → `stop`=1 cycles 0–32, `div_complete` only at cycle 33, `quot`=14, `rem`=2.
- DIV -7/2 (0xFFFFFFF9 / 2) → `quot`=0xFFFFFFFD, `rem`=0xFFFFFFFF; DIV 7/-2 → `quot`=0xFFFFFFFD, `rem`=1.
- DIV 0x80000000 / 0xFFFFFFFF → `quot`=0x80000000, `rem`=0. DIVU 5/0 → `quot`=0xFFFFFFFF, `rem`=5.
- Start DIVU 100/7, then pulse `flush` at cycle 10:
  - `stop`=0 in cycle 10 and `busy`=0 from cycle 11.
  - No `div_complete`; `quot`/`rem` hold their old values.
  - A new DIVU 9/3 at cycle 12 completes at cycle 45 with 3/0.
- Back-to-back: DIVU 50/5 then DIVU 9/4 with `div_req` held.
  - First pulse at cycle 33 (10/0).
  - Second accepted at cycle 34, pulse at cycle 67 (2/1).
- Assert `rst` at cycle 20 of an active divide → next cycle state IDLE, `quot`=`rem`=0, `stop`=`busy`=0, no pulse.
